// File: rtl/alu_result_serializer_pkg.sv
// Shared definitions for the ALU result serializer.
// Frame header layout, byte width and FSM state encoding.
package alu_result_serializer_pkg;

    localparam int BYTE_W = 8;
    localparam logic [3:0] FRAME_HDR_NIBBLE = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    function automatic logic [7:0] frame_hdr(input logic carry);
        return {FRAME_HDR_NIBBLE, 3'b000, carry};
    endfunction

endpackage

// File: rtl/alu_result_serializer_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data.
// Push while full is accepted only when a pop frees a slot.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results and streams each one as a header+data byte frame.
// Back-to-back frames chain without an idle cycle.
module alu_result_serializer
    import alu_result_serializer_pkg::*;
#(
    parameter int OUT_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
    input  logic                      Carry_OUT,
    input  logic                      Arith_Flag,
    input  logic                      TX_READY,
    output logic [7:0]                TX_DATA,
    output logic                      TX_VALID,
    output logic                      TX_LAST,
    output logic                      FIFO_FULL,
    output logic [DROP_CNT_WIDTH-1:0] DROP_CNT,
    output logic                      BUSY
);

    localparam int NB = OUT_DATA_WIDTH / BYTE_W;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                    state;
    state_t                    state_nxt;
    logic [OUT_DATA_WIDTH:0]   fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic                      pop;
    logic [OUT_DATA_WIDTH-1:0] data_q;
    logic                      carry_q;
    logic [IW-1:0]             idx;
    logic                      idx_last;

    sync_fifo #(
        .WIDTH(OUT_DATA_WIDTH + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (CLK),
        .rst_n(RST),
        .push (Arith_Flag),
        .pop  (pop),
        .wdata({Carry_OUT, Arith_OUT}),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    assign idx_last  = (idx == IW'(NB - 1));
    assign FIFO_FULL = fifo_full;
    assign BUSY      = (state != ST_IDLE) || (fifo_count != '0);

    // Frame state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next state, FIFO pop and link outputs.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        TX_VALID  = 1'b0;
        TX_LAST   = 1'b0;
        TX_DATA   = 8'h00;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                TX_VALID = 1'b1;
                TX_DATA  = frame_hdr(carry_q);
                if (TX_READY) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                TX_VALID = 1'b1;
                TX_LAST  = idx_last;
                TX_DATA  = data_q[OUT_DATA_WIDTH-1 -: BYTE_W];
                if (TX_READY && idx_last) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = ST_HDR;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Load a result on pop; shift out one byte per accepted data beat.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q  <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
        end else if (pop) begin
            data_q  <= fifo_rdata[OUT_DATA_WIDTH-1:0];
            carry_q <= fifo_rdata[OUT_DATA_WIDTH];
            idx     <= '0;
        end else if (state == ST_DATA && TX_READY) begin
            data_q  <= data_q << BYTE_W;
            idx     <= idx + IW'(1);
        end
    end

    // Count results lost because no slot was free; saturates.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            DROP_CNT <= '0;
        end else if (Arith_Flag && fifo_full && !pop && (DROP_CNT != '1)) begin
            DROP_CNT <= DROP_CNT + DROP_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench for alu_result_serializer.
// Transaction-level model: result queue plus the frame on the link.
module tb_alu_result_serializer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] Arith_OUT = '0;
    logic        Carry_OUT = 1'b0;
    logic        Arith_Flag = 1'b0;
    logic        TX_READY = 1'b0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_LAST;
    logic        FIFO_FULL;
    logic [7:0]  DROP_CNT;
    logic        BUSY;

    int total = 0;
    int bad = 0;

    logic [32:0] mq[$];
    logic [32:0] mcur;
    int          mrem;
    bit          mbusy;
    int          mdrop;

    alu_result_serializer dut (
        .CLK       (CLK),
        .RST       (RST),
        .Arith_OUT (Arith_OUT),
        .Carry_OUT (Carry_OUT),
        .Arith_Flag(Arith_Flag),
        .TX_READY  (TX_READY),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .TX_LAST   (TX_LAST),
        .FIFO_FULL (FIFO_FULL),
        .DROP_CNT  (DROP_CNT),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic void model_reset();
        mq.delete();
        mcur  = '0;
        mrem  = 0;
        mbusy = 0;
        mdrop = 0;
    endfunction

    // Byte currently offered: 5 bytes left means header, then MSB first.
    function automatic logic [7:0] exp_byte();
        if (mrem == 5) return {4'hA, 3'b000, mcur[32]};
        return mcur[mrem*8-1 -: 8];
    endfunction

    function automatic logic [19:0] exp_vec();
        logic [7:0] d;
        d = mbusy ? exp_byte() : 8'h00;
        return {mbusy, mbusy && (mrem == 1), d, mq.size() == 4,
                mbusy || (mq.size() > 0), 8'(mdrop)};
    endfunction

    function automatic logic [19:0] obs_vec();
        return {TX_VALID, TX_LAST, TX_DATA, FIFO_FULL, BUSY, DROP_CNT};
    endfunction

    // One clock edge of the abstract model, given the inputs at that edge.
    function automatic void model_step(bit f, logic [31:0] d, bit c, bit r);
        bit fire;
        bit fin;
        bit take;
        bit acc;
        fire = mbusy && r;
        fin  = fire && (mrem == 1);
        take = (mq.size() > 0) && (!mbusy || fin);
        acc  = (mq.size() < 4) || take;
        if (fire) begin
            mrem--;
            if (mrem == 0) mbusy = 0;
        end
        if (take) begin
            mcur  = mq.pop_front();
            mrem  = 5;
            mbusy = 1;
        end
        if (f) begin
            if (acc) mq.push_back({c, d});
            else if (mdrop < 255) mdrop++;
        end
    endfunction

    task automatic cycle(input bit f, input logic [31:0] d,
                         input bit c, input bit r);
        Arith_Flag = f;
        Arith_OUT  = d;
        Carry_OUT  = c;
        TX_READY   = r;
        @(posedge CLK);
        model_step(f, d, c, r);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #3;
        total++;
        if (obs_vec() !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", obs_vec(), 20'h0);
        end
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 1);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reset_idle got=%h want=%h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] lit [5];
        lit = '{8'hA1, 8'h12, 8'h34, 8'h56, 8'h78};
        cycle(1, 32'h1234_5678, 1, 1);
        total++;
        if (TX_VALID !== 1'b0) begin
            bad++;
            $display("FAIL single_early got=%b want=0", TX_VALID);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 1);
            total++;
            if ({TX_VALID, TX_LAST, TX_DATA} !== {1'b1, i == 4, lit[i]}) begin
                bad++;
                $display("FAIL single_byte%0d got=%b/%b/%h want=1/%b/%h",
                         i, TX_VALID, TX_LAST, TX_DATA, i == 4, lit[i]);
            end
        end
        cycle(0, 0, 0, 1);
        total++;
        if ({TX_VALID, BUSY} !== 2'b00) begin
            bad++;
            $display("FAIL single_end got=%b%b want=00", TX_VALID, BUSY);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$];
        int first;
        int last;
        first = -1;
        last  = -1;
        for (int i = 0; i < 19; i++) begin
            if (i < 3) cycle(1, 32'(i + 1), 0, 1);
            else       cycle(0, 0, 0, 1);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL b2b_model i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (TX_VALID === 1'b1) begin
                got.push_back(TX_DATA);
                if (first < 0) first = i;
                last = i;
            end
        end
        total++;
        if (got.size() != 15 || (last - first) != 14) begin
            bad++;
            $display("FAIL b2b_gap got=%0d bytes span=%0d want=15 span=14",
                     got.size(), last - first);
        end
        for (int f = 0; f < 3 && got.size() == 15; f++) begin
            for (int b = 0; b < 5; b++) begin
                logic [7:0] w;
                w = (b == 0) ? 8'hA0 : (b == 4) ? 8'(f + 1) : 8'h00;
                total++;
                if (got[f*5+b] !== w) begin
                    bad++;
                    $display("FAIL b2b_byte f=%0d b=%0d got=%h want=%h",
                             f, b, got[f*5+b], w);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit         rd [9];
        logic [7:0] want [5];
        logic [7:0] got[$];
        rd   = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
        want = '{8'hA0, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        cycle(1, 32'hCAFE_F00D, 0, 1);
        for (int i = 0; i < 9; i++) begin
            if (TX_VALID === 1'b1 && rd[i]) got.push_back(TX_DATA);
            cycle(0, 0, 0, rd[i]);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL stall_model i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (got.size() != 5) begin
            bad++;
            $display("FAIL stall_count got=%0d want=5", got.size());
        end else begin
            for (int b = 0; b < 5; b++) begin
                total++;
                if (got[b] !== want[b]) begin
                    bad++;
                    $display("FAIL stall_byte b=%0d got=%h want=%h", b, got[b], want[b]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] got[$];
        logic [7:0] w;
        logic [32:0] r;
        int drop0;
        drop0 = mdrop;
        cycle(1, 32'h100, 1, 0);
        for (int i = 0; i < 6; i++) cycle(1, 32'h101 + 32'(i), 0, 0);
        total++;
        if ({FIFO_FULL, DROP_CNT} !== {1'b1, 8'(drop0 + 2)}) begin
            bad++;
            $display("FAIL ovf_full got=%b/%0d want=1/%0d", FIFO_FULL, DROP_CNT, drop0 + 2);
        end
        for (int i = 0; i < 30; i++) begin
            if (TX_VALID === 1'b1) got.push_back(TX_DATA);
            cycle(0, 0, 0, 1);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL ovf_model i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (got.size() != 25) begin
            bad++;
            $display("FAIL ovf_count got=%0d want=25", got.size());
        end else begin
            for (int f = 0; f < 5; f++) begin
                r = {f == 0, 32'h100 + 32'(f)};
                for (int b = 0; b < 5; b++) begin
                    w = (b == 0) ? {7'b1010000, r[32]} : r[39-8*b -: 8];
                    total++;
                    if (got[f*5+b] !== w) begin
                        bad++;
                        $display("FAIL ovf_byte f=%0d b=%0d got=%h want=%h",
                                 f, b, got[f*5+b], w);
                    end
                end
            end
        end
    endtask

    task automatic test_push_pop_full();
        bit f;
        int drop0;
        for (int i = 0; i < 5; i++) cycle(1, 32'hAB00 + 32'(i), 0, 0);
        drop0 = mdrop;
        total++;
        if (FIFO_FULL !== 1'b1) begin
            bad++;
            $display("FAIL ppf_prefull got=%b want=1", FIFO_FULL);
        end
        for (int i = 0; i < 10; i++) begin
            f = mbusy && (mrem == 1);
            cycle(f, 32'hBEEF_0000 + 32'(i), 1, 1);
            if (f) break;
        end
        total++;
        if ({FIFO_FULL, DROP_CNT} !== {1'b1, 8'(drop0)}) begin
            bad++;
            $display("FAIL ppf_accept got=%b/%0d want=1/%0d", FIFO_FULL, DROP_CNT, drop0);
        end
        for (int i = 0; i < 30; i++) begin
            cycle(0, 0, 0, 1);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL ppf_model i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit f;
        bit r;
        for (int i = 0; i < 600; i++) begin
            f = ($urandom_range(0, 3) == 0) || (i % 100 < 8);
            r = ($urandom_range(0, 3) != 0);
            cycle(f, $urandom, 1'($urandom), r);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rand_model i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 30; i++) cycle(0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        cycle(1, 32'hDEAD_BEEF, 1, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        #1;
        RST = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs_vec() !== 20'h0) begin
            bad++;
            $display("FAIL rstmid_outputs got=%h want=%h", obs_vec(), 20'h0);
        end
        @(negedge CLK);
        RST = 1'b1;
        cycle(1, 32'h0BAD_F00D, 0, 1);
        cycle(0, 0, 0, 1);
        total++;
        if ({TX_VALID, TX_DATA} !== {1'b1, 8'hA0}) begin
            bad++;
            $display("FAIL rstmid_hdr got=%b/%h want=1/a0", TX_VALID, TX_DATA);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 1);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rstmid_model i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) cycle(1, 32'(i), 0, 0);
        total++;
        if ({FIFO_FULL, DROP_CNT} !== {1'b1, 8'hFF}) begin
            bad++;
            $display("FAIL sat_cnt got=%b/%h want=1/ff", FIFO_FULL, DROP_CNT);
        end
        for (int i = 0; i < 30; i++) begin
            cycle(0, 0, 0, 1);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL sat_model i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_push_pop_full();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
